// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned MD_XLEN        = 32;
    localparam int unsigned MD_ITER        = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FAST = 2'd2;
    localparam logic [1:0] MD_DONE = 2'd3;

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-to-muldiv request and EX/MEM-facing result/stall signals.
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = MD_XLEN
);
    logic                      start;
    logic [2:0]                funct3;
    logic [XLEN-1:0]           op_a;
    logic [XLEN-1:0]           op_b;
    logic [REG_ADDR_WIDTH-1:0] rd_in;
    logic                      flush;
    logic                      stall;
    logic                      done;
    logic [XLEN-1:0]           result;
    logic [REG_ADDR_WIDTH-1:0] rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in, flush,
        input  stall, done, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, flush,
        output stall, done, result, rd_out
    );
endinterface

// File: rtl/ex_muldiv_core.sv
// Unsigned iterative datapath: shift-add multiply / restoring divide, one bit per cycle.
module muldiv_core #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc_next,
    output logic              last
);
    localparam int unsigned CNT_W = $clog2(ITER);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   b_reg;
    logic              div_r;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     trial;

    // acc = {hi, lo}; lo starts as multiplier/dividend, hi collects product/remainder
    always_comb begin
        sum      = '0;
        trial    = '0;
        acc_next = acc;
        if (div_r) begin
            trial = acc[2*XLEN-1:XLEN-1] - {1'b0, b_reg};
            if (!trial[XLEN])
                acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_next = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_reg} : '0);
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

    assign last = (cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            b_reg <= '0;
            div_r <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            acc   <= {{XLEN{1'b0}}, a_mag};
            b_reg <= b_mag;
            div_r <= is_div;
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc_next;
            cnt   <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide for the EX stage: FSM, sign handling, special cases, stall.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = MD_XLEN,
    parameter int unsigned ITER = MD_ITER
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    logic [1:0]                state, state_nxt;
    logic [2:0]                f3_r;
    logic [REG_ADDR_WIDTH-1:0] rd_r;
    logic                      neg_q, neg_r;
    logic [XLEN-1:0]           spec_r;

    logic              accept, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, ovf, is_special;
    logic [XLEN-1:0]   a_mag, b_mag, spec_val, final_res;
    logic [2*XLEN-1:0] acc_next, prod;
    logic              last;

    assign accept   = (state == MD_IDLE) && bus.start && !bus.flush;
    assign a_signed = (bus.funct3 == MULDIV_MULH) || (bus.funct3 == MULDIV_MULHSU) ||
                      (bus.funct3 == MULDIV_DIV)  || (bus.funct3 == MULDIV_REM);
    assign b_signed = (bus.funct3 == MULDIV_MULH) || (bus.funct3 == MULDIV_DIV) ||
                      (bus.funct3 == MULDIV_REM);
    assign a_neg    = a_signed && bus.op_a[XLEN-1];
    assign b_neg    = b_signed && bus.op_b[XLEN-1];
    assign a_mag    = a_neg ? -bus.op_a : bus.op_a;
    assign b_mag    = b_neg ? -bus.op_b : bus.op_b;

    // Cases the iterative divider cannot produce correctly, resolved in one cycle
    assign div_zero   = bus.funct3[2] && (bus.op_b == '0);
    assign ovf        = ((bus.funct3 == MULDIV_DIV) || (bus.funct3 == MULDIV_REM)) &&
                        (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    assign is_special = div_zero || ovf;
    assign spec_val   = div_zero ? (bus.funct3[1] ? bus.op_a : '1)
                                 : (bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    muldiv_core #(.XLEN(XLEN), .ITER(ITER)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (state == MD_CALC),
        .is_div   (bus.funct3[2]),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_next (acc_next),
        .last     (last)
    );

    // Sign fix-up of the final step; remainder follows the dividend's sign
    assign prod = neg_q ? -acc_next : acc_next;
    always_comb begin
        final_res = '0;
        if (!f3_r[2])
            final_res = (f3_r == MULDIV_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (!f3_r[1])
            final_res = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        else
            final_res = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept) state_nxt = is_special ? MD_FAST : MD_CALC;
            MD_CALC: begin
                if (bus.flush)  state_nxt = MD_IDLE;
                else if (last)  state_nxt = MD_DONE;
            end
            MD_FAST: state_nxt = bus.flush ? MD_IDLE : MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign bus.stall = accept || (state == MD_CALC) || (state == MD_FAST);

    // Operand context capture and the one-cycle result presentation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_r       <= '0;
            rd_r       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            spec_r     <= '0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.rd_out <= '0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                f3_r   <= bus.funct3;
                rd_r   <= bus.rd_in;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                spec_r <= spec_val;
            end
            if (!bus.flush && (state == MD_CALC) && last) begin
                bus.done   <= 1'b1;
                bus.result <= final_res;
                bus.rd_out <= rd_r;
            end else if (!bus.flush && (state == MD_FAST)) begin
                bus.done   <= 1'b1;
                bus.result <= spec_r;
                bus.rd_out <= rd_r;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: results, latency, flush, async reset.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32)) bus ();

    ex_muldiv #(.XLEN(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction and hold it (as ID/EX would) until done
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        int n, stall_cnt;
        @(negedge clk);
        chk({tag, "_idle_done"}, 64'(bus.done), 64'(0));
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        #1;
        n = 0;
        stall_cnt = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.stall === 1'b1) stall_cnt++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(lat));
        chk({tag, "_result"}, 64'(bus.result), 64'(exp));
        chk({tag, "_rd_out"}, 64'(bus.rd_out), 64'(rd));
        chk({tag, "_done_stall"}, 64'(bus.stall), 64'(0));
        bus.start = 1'b0;
    endtask

    initial begin
        int saw_done;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;

        // Reset state
        #12;
        chk("rst_stall", 64'(bus.stall), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_rd_out", 64'(bus.rd_out), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_start_stall", 64'(bus.stall), 64'(0));

        run_op("mul",    MULDIV_MUL,    32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
        run_op("mulh",   MULDIV_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 33);
        run_op("mulhu",  MULDIV_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 33);
        run_op("mulhsu", MULDIV_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd6, 32'hFFFF_FFFF, 33);
        run_op("div",    MULDIV_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFD, 33);
        run_op("rem",    MULDIV_REM,    32'hFFFF_FFF9, 32'd2,         5'd8, 32'hFFFF_FFFF, 33);
        run_op("divu",   MULDIV_DIVU,   32'd100,       32'd7,         5'd9, 32'd14,        33);
        run_op("remu",   MULDIV_REMU,   32'd100,       32'd7,         5'd10, 32'd2,        33);
        run_op("divu0",  MULDIV_DIVU,   32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 2);
        run_op("rem0",   MULDIV_REM,    32'd5,         32'd0,         5'd12, 32'd5,         2);
        run_op("divovf", MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 2);
        run_op("removf", MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         2);

        // Flush at CALC cycle 10
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = MULDIV_MUL;
        bus.op_a   = 32'd9;
        bus.op_b   = 32'd9;
        bus.rd_in  = 5'd15;
        saw_done   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done++;
        end
        chk("flush_calc_stall", 64'(bus.stall), 64'(1));
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_stall_drop", 64'(bus.stall), 64'(0));
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) saw_done++;
            if (i < 39) @(negedge clk);
        end
        chk("flush_no_done", 64'(saw_done), 64'(0));
        run_op("mul_after_flush", MULDIV_MUL, 32'd3, 32'd4, 5'd16, 32'd12, 33);

        // Async reset in CALC cycle 5
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = MULDIV_DIVU;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd3;
        bus.rd_in  = 5'd17;
        repeat (5) @(negedge clk);
        #2;
        rst       = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("midrst_stall", 64'(bus.stall), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        chk("midrst_result", 64'(bus.result), 64'(0));
        chk("midrst_rd_out", 64'(bus.rd_out), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back: second DIV accepted in the IDLE cycle after DONE
        run_op("b2b_div1", MULDIV_DIV, 32'd20, 32'hFFFF_FFFB, 5'd18, 32'hFFFF_FFFC, 33);
        run_op("b2b_div2", MULDIV_DIV, 32'hFFFF_FFEC, 32'd6, 5'd19, 32'hFFFF_FFFD, 33);
        @(negedge clk);
        chk("final_done_low", 64'(bus.done), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
